// File: rtl/add_arbiter_if.sv
// Handshake bundle between four operand requesters, the shared-adder arbiter and the result consumer.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high; valid must not depend on ready.
interface add_arbiter_if #(parameter int WIDTH = 32);
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_y;
  logic               res_carry;
  logic [1:0]         res_id;
  logic               dbg_state;
  logic [1:0]         dbg_rr_ptr;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_y, res_carry, res_id, dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_y, res_carry, res_id, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/add_arbiter.sv
// Four-way round-robin arbiter feeding one shared adder into a single-entry output register.
// The output register drains and reloads in the same cycle, so throughput is one result per cycle.
module add_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  add_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic [1:0]       id_q, id_d;

  logic             can_load;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic             fire;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum;

  // Scan from the farthest offset down so the nearest valid requester above rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign can_load      = (state_q == EMPTY) || bus.res_ready;
  assign fire          = can_load && grant_found && !rst;
  assign bus.req_ready = fire ? (4'b0001 << grant_idx) : 4'b0000;

  assign a_sel = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    y_d      = y_q;
    carry_d  = carry_q;
    id_d     = id_q;
    if (fire) begin
      state_d  = FULL;
      rr_ptr_d = grant_idx + 2'd1;
      y_d      = sum[WIDTH-1:0];
      carry_d  = sum[WIDTH];
      id_d     = grant_idx;
    end else if (state_q == FULL && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= 2'd0;
      y_q      <= '0;
      carry_q  <= 1'b0;
      id_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      y_q      <= y_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
    end
  end

  assign bus.res_valid  = (state_q == FULL);
  assign bus.res_y      = y_q;
  assign bus.res_carry  = carry_q;
  assign bus.res_id     = id_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL serve exactly 4 requesters, numbered 0..3; the count is fixed and SHALL NOT be a parameter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  4  bit i high means requester i presents an operand pair.
REQ-006 req_a  input  4*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  4*WIDTH  operand B; same packing as req_a.
REQ-008 req_ready  output  4  bit i high means requester i's pair is accepted this cycle; at most one bit SHALL be high.
REQ-009 res_valid  output  1  a result is held in the output register.
REQ-010 res_ready  input  1  the consumer takes the result this cycle.
REQ-011 res_y  output  WIDTH  sum (a+b) mod 2^WIDTH.
REQ-012 res_carry  output  1  carry out of bit WIDTH-1.
REQ-013 res_id  output  2  index of the requester that owns res_y.

Function
REQ-014 The block SHALL contain one shared WIDTH-bit adder; only the granted requester's operands SHALL reach it.
REQ-015 The block SHALL use a two-state FSM: EMPTY (no result held) and FULL (result held); res_valid SHALL be high exactly in FULL.
REQ-016 The output register SHALL be able to load ("can_load") when in EMPTY, or when in FULL with res_ready high in the same cycle.
REQ-017 When can_load is high and any req_valid bit is high, the block SHALL grant the first valid requester found by searching upward from rr_ptr, modulo 4.
REQ-018 The block SHALL drive req_ready combinationally from req_valid, rr_ptr and FSM state, and SHALL set it only for the granted requester.
REQ-019 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on that edge the block SHALL register res_y, res_carry and res_id=i, and the state SHALL become FULL.
REQ-020 Latency SHALL be 1 cycle: a result accepted at edge N SHALL be visible on res_* immediately after edge N.
REQ-021 On a transfer from requester i, rr_ptr SHALL become (i+1) mod 4; otherwise rr_ptr SHALL hold.
REQ-022 In FULL with res_ready low, res_y, res_carry and res_id SHALL hold stable and all req_ready bits SHALL be low.
REQ-023 In FULL with res_ready high and no valid requester, the state SHALL return to EMPTY.
REQ-024 In FULL with res_ready high and a valid requester, the block SHALL drain and load in the same cycle, staying in FULL with no bubble, so throughput is 1 result per cycle.
REQ-025 If no req_valid bit is high, no grant SHALL occur and rr_ptr SHALL not change.
REQ-026 res_ready received while in EMPTY SHALL be ignored.
REQ-027 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported only on res_carry.
REQ-028 A requester with req_valid held high SHALL be granted within 4 results, so there is no starvation.

Reset
REQ-029 While rst is high: state=EMPTY, rr_ptr=0, res_valid=0, res_y=0, res_carry=0, res_id=0, req_ready=0.
REQ-030 Reset asserted mid-operation SHALL discard any held result without a handshake; after release the first grant SHALL search from requester 0.

Verification
REQ-031 Reset, then req_valid=0001 with a=5, b=7, res_ready=1 -> req_ready=0001 in cycle 0; in cycle 1 res_valid=1, res_y=12, res_carry=0, res_id=0.
REQ-032 WIDTH=32, requester 2 with a=FFFFFFFF, b=00000002 -> res_y=00000001, res_carry=1, res_id=2.
REQ-033 req_valid=1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles, with res_valid continuously high.
REQ-034 res_ready=0 for 3 cycles with result 12/id 1 held and req_valid=1111 -> res_* stable and req_ready=0000 throughout; on res_ready=1, requester 2 is granted in the same cycle.
REQ-035 rst pulsed while FULL, between clock edges -> res_valid=0 immediately; the next grant with req_valid=1010 goes to requester 1.
REQ-036 Random bench: every accepted pair appears exactly once with the correct sum, carry and id; the scoreboard checks ordering and the 4-result fairness bound.
